switch_input_ctrl: RTL



---
 rtl/sw_io_pkg.sv | 21 ++
 rtl/sw_debounce_lane.sv | 55 +++++
 rtl/switch_input_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/sw_io_pkg.sv
// Shared constants and types for the memory-mapped switch input peripheral.
// Holds register offsets, default debounce timing and the read-select decode.
package sw_io_pkg;

  localparam int SW_W            = 16;
  localparam logic [31:0] OFFS_SW_VAL = 32'h0000_0000;
  localparam logic [31:0] OFFS_SW_CHG = 32'h0000_0004;
  localparam int DEF_TICK_DIV    = 100000;
  localparam int DEF_DEB_SAMPLES = 4;

  typedef enum logic {
    SEL_VAL = 1'b0,
    SEL_CHG = 1'b1
  } rd_sel_e;

  // Only address bit 2 distinguishes the two registers; upstream decodes the range.
  function automatic rd_sel_e decode_sel(input logic addr_bit2);
    return (addr_bit2 == OFFS_SW_CHG[2]) ? SEL_CHG : SEL_VAL;
  endfunction

endpackage

// File: rtl/sw_debounce_lane.sv
// One switch bit: two-flop synchronizer, tick-driven sample shift register
// and debounced stable bit with a one-cycle change pulse.
module sw_debounce_lane
  import sw_io_pkg::*;
#(
  parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic tick,
  input  logic eval,
  output logic stable,
  output logic chg_set
);

  logic                   sync1;
  logic                   sync2;
  logic [DEB_SAMPLES-1:0] samples;
  logic                   all_one;
  logic                   all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples <= '0;
    end else if (tick) begin
      samples <= {samples[DEB_SAMPLES-2:0], sync2};
    end
  end

  assign all_one  = &samples;
  assign all_zero = ~|samples;

  // eval is the cycle after a shift, so the window is judged once per tick.
  assign chg_set = eval & ((all_one & ~stable) | (all_zero & stable));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
    end else if (chg_set) begin
      stable <= ~stable;
    end
  end

endmodule

// File: rtl/switch_input_ctrl.sv
// Switch peripheral: debounced switch value and sticky clear-on-read change flags.
// Optional `SW_IRQ_EN adds a registered change-pending indicator on sw_irq.
module switch_input_ctrl
  import sw_io_pkg::*;
#(
  parameter int NUM_SW      = SW_W,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  sw_in,
  input  logic             SwitchCtrl,
  input  logic             ioRead,
  input  logic [31:0]      addr_in,
  output logic [SW_W-1:0]  io_rdata,
  output logic             sw_irq
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]   presc;
  logic            tick;
  logic            tick_d;
  logic [SW_W-1:0] stable;
  logic [SW_W-1:0] chg_set;
  logic [SW_W-1:0] chg;
  logic            rd;
  rd_sel_e         sel;
  logic            flag_clr;
  logic            unused_addr;

  assign tick = (presc == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      tick_d <= 1'b0;
    end else begin
      presc  <= tick ? '0 : presc + CW'(1);
      tick_d <= tick;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
    sw_debounce_lane #(
      .DEB_SAMPLES(DEB_SAMPLES)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin    (sw_in[i]),
      .tick   (tick),
      .eval   (tick_d),
      .stable (stable[i]),
      .chg_set(chg_set[i])
    );
  end

  assign rd          = SwitchCtrl & ioRead;
  assign sel         = decode_sel(addr_in[2]);
  assign flag_clr    = rd & (sel == SEL_CHG);
  assign unused_addr = ^{addr_in[31:3], addr_in[1:0]};

  // A change landing in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg <= '0;
    end else if (flag_clr) begin
      chg <= chg_set;
    end else begin
      chg <= chg | chg_set;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (rd) begin
      case (sel)
        SEL_CHG: io_rdata = chg;
        default: io_rdata = stable;
      endcase
    end
  end

`ifdef SW_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_irq <= 1'b0;
    end else begin
      sw_irq <= |chg;
    end
  end
`else
  assign sw_irq = 1'b0;
`endif

endmodule
